washing_machine_plant_model: RTL and testbench

//  Behavioural-synthesizable plant model: the far end of the controller's actuator/sensor interface.

---
 rtl/washing_machine_plant_model_if.sv | 27 ++
 rtl/washing_machine_plant_model.sv | 164 ++++++++++++++++
 tb/tb_washing_machine_plant_model.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/washing_machine_plant_model_if.sv
// rtl/washing_machine_plant_model_if.sv - actuator command / sensor feedback bundle between washer controller and plant
interface washing_machine_plant_model_if;
  logic       water_valve;
  logic       heater;
  logic       drum_motor;
  logic       drain_pump;
  logic       door_lock;
  logic       inject_imbalance;
  logic [9:0] water_level;
  logic [9:0] temperature_adc;
  logic [9:0] motor_speed_sensor;
  logic       door_locked;
  logic       vibration_sensor;
  logic       dry_heat_fault;

  modport master (
    output water_valve, heater, drum_motor, drain_pump, door_lock, inject_imbalance,
    input  water_level, temperature_adc, motor_speed_sensor, door_locked, vibration_sensor,
           dry_heat_fault
  );

  modport slave (
    input  water_valve, heater, drum_motor, drain_pump, door_lock, inject_imbalance,
    output water_level, temperature_adc, motor_speed_sensor, door_locked, vibration_sensor,
           dry_heat_fault
  );
endinterface

// File: rtl/washing_machine_plant_model.sv
// rtl/washing_machine_plant_model.sv - tick-driven plant model: water, temperature, drum speed, door latch
module washing_machine_plant_model #(
  parameter int unsigned TICK_DIV       = 100,
  parameter int unsigned FILL_RATE      = 8,
  parameter int unsigned DRAIN_RATE     = 12,
  parameter int unsigned HEAT_RATE      = 2,
  parameter int unsigned AMBIENT_TEMP   = 100,
  parameter int unsigned HEAT_MIN_LEVEL = 64,
  parameter int unsigned ACCEL          = 10,
  parameter int unsigned DECEL          = 20,
  parameter int unsigned MAX_RPM        = 1000,
  parameter int unsigned VIB_SPEED      = 700,
  parameter int unsigned LOCK_DELAY     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  washing_machine_plant_model_if.slave  bus
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LCNT_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_DELAY - 1);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKING   = 2'd1,
    LOCKED    = 2'd2,
    UNLOCKING = 2'd3
  } door_state_e;

  logic [CNT_W-1:0]  presc_q;
  logic              tick;
  logic [9:0]        level_q, level_d;
  logic [9:0]        temp_q, temp_d;
  logic [9:0]        speed_q, speed_d;
  logic              vib_q, vib_d;
  logic              fault_q, fault_d;
  door_state_e       door_q, door_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;

  logic signed [11:0] lvl_sum;
  logic [10:0]        temp_up;
  logic [10:0]        speed_up;
  logic               heat_ok;

  assign tick = (presc_q == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Plant dynamics; every physical quantity saturates instead of wrapping.
  always_comb begin
    lvl_sum = $signed({2'b00, level_q});
    if (bus.water_valve) lvl_sum = lvl_sum + $signed(12'(FILL_RATE));
    if (bus.drain_pump)  lvl_sum = lvl_sum - $signed(12'(DRAIN_RATE));
    if (lvl_sum < 12'sd0) begin
      level_d = 10'd0;
    end else if (lvl_sum > 12'sd1023) begin
      level_d = 10'd1023;
    end else begin
      level_d = lvl_sum[9:0];
    end

    heat_ok = bus.heater && (level_q >= 10'(HEAT_MIN_LEVEL));
    temp_up = {1'b0, temp_q} + 11'(HEAT_RATE);
    if (heat_ok) begin
      temp_d = (temp_up > 11'd1023) ? 10'd1023 : temp_up[9:0];
    end else if (temp_q > 10'(AMBIENT_TEMP)) begin
      temp_d = temp_q - 10'd1;
    end else if (temp_q < 10'(AMBIENT_TEMP)) begin
      temp_d = temp_q + 10'd1;
    end else begin
      temp_d = temp_q;
    end

    fault_d = fault_q | (bus.heater && (level_q < 10'(HEAT_MIN_LEVEL)));

    speed_up = {1'b0, speed_q} + 11'(ACCEL);
    if (bus.drum_motor) begin
      speed_d = (speed_up > 11'(MAX_RPM)) ? 10'(MAX_RPM) : speed_up[9:0];
    end else if ({1'b0, speed_q} <= 11'(DECEL)) begin
      speed_d = 10'd0;
    end else begin
      speed_d = speed_q - 10'(DECEL);
    end

    vib_d = bus.inject_imbalance && (speed_d >= 10'(VIB_SPEED));
  end

  // Door latch; a spinning drum keeps the door locked regardless of command.
  always_comb begin
    door_d = door_q;
    lcnt_d = lcnt_q;
    case (door_q)
      UNLOCKED: begin
        if (bus.door_lock) begin
          door_d = LOCKING;
          lcnt_d = '0;
        end
      end
      LOCKING: begin
        if (!bus.door_lock) begin
          door_d = UNLOCKED;
        end else if (lcnt_q == LOCK_LAST) begin
          door_d = LOCKED;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (!bus.door_lock && (speed_q == 10'd0)) begin
          door_d = UNLOCKING;
          lcnt_d = '0;
        end
      end
      UNLOCKING: begin
        if (bus.door_lock) begin
          door_d = LOCKED;
        end else if (lcnt_q == LOCK_LAST) begin
          door_d = UNLOCKED;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: door_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 10'd0;
      temp_q  <= 10'(AMBIENT_TEMP);
      speed_q <= 10'd0;
      vib_q   <= 1'b0;
      fault_q <= 1'b0;
      door_q  <= UNLOCKED;
      lcnt_q  <= '0;
    end else if (tick) begin
      level_q <= level_d;
      temp_q  <= temp_d;
      speed_q <= speed_d;
      vib_q   <= vib_d;
      fault_q <= fault_d;
      door_q  <= door_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign bus.water_level        = level_q;
  assign bus.temperature_adc    = temp_q;
  assign bus.motor_speed_sensor = speed_q;
  assign bus.vibration_sensor   = vib_q;
  assign bus.dry_heat_fault     = fault_q;
  assign bus.door_locked        = (door_q == LOCKED) || (door_q == UNLOCKING);

endmodule

// File: tb/tb_washing_machine_plant_model.sv
// tb/tb_washing_machine_plant_model.sv - self-checking bench for the washer plant model
module tb_washing_machine_plant_model;
  localparam int FILL = 8, DRAIN = 12, HEAT = 2, AMB = 100, HMIN = 64;
  localparam int ACC = 10, DEC = 20, MAXR = 1000, VIB = 700, LD = 3;

  logic clk = 1'b0;
  logic rst;
  logic rst100;
  always #5 clk = ~clk;

  washing_machine_plant_model_if bus1();
  washing_machine_plant_model_if bus100();

  washing_machine_plant_model #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );
  washing_machine_plant_model #(.TICK_DIV(100)) dut100 (
    .clk(clk), .reset(rst100), .bus(bus100)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference plant: plain integers, door as locked flag plus pending-change timers.
  int m_lvl, m_tmp, m_spd, m_cnt;
  bit m_fault, m_vib, m_locked, m_lock_pend, m_unlock_pend;

  task automatic model_reset();
    m_lvl = 0; m_tmp = AMB; m_spd = 0; m_cnt = 0;
    m_fault = 0; m_vib = 0; m_locked = 0; m_lock_pend = 0; m_unlock_pend = 0;
  endtask

  task automatic model_step(input bit v, h, m, p, l, imb);
    int nl, nt, ns;
    nl = m_lvl + (v ? FILL : 0) - (p ? DRAIN : 0);
    if (nl < 0) nl = 0;
    if (nl > 1023) nl = 1023;
    if (h && m_lvl >= HMIN) nt = (m_tmp + HEAT > 1023) ? 1023 : m_tmp + HEAT;
    else if (m_tmp > AMB) nt = m_tmp - 1;
    else if (m_tmp < AMB) nt = m_tmp + 1;
    else nt = m_tmp;
    if (h && m_lvl < HMIN) m_fault = 1;
    ns = m ? ((m_spd + ACC > MAXR) ? MAXR : m_spd + ACC) : ((m_spd - DEC < 0) ? 0 : m_spd - DEC);
    m_vib = imb && (ns >= VIB);
    if (!m_locked) begin
      if (!m_lock_pend) begin
        if (l) begin m_lock_pend = 1; m_cnt = 0; end
      end else if (!l) begin
        m_lock_pend = 0;
      end else begin
        m_cnt++;
        if (m_cnt == LD) begin m_locked = 1; m_lock_pend = 0; end
      end
    end else begin
      if (!m_unlock_pend) begin
        if (!l && m_spd == 0) begin m_unlock_pend = 1; m_cnt = 0; end
      end else if (l) begin
        m_unlock_pend = 0;
      end else begin
        m_cnt++;
        if (m_cnt == LD) begin m_locked = 0; m_unlock_pend = 0; end
      end
    end
    m_lvl = nl; m_tmp = nt; m_spd = ns;
  endtask

  task automatic cyc(input bit v, h, m, p, l, imb);
    @(negedge clk);
    bus1.water_valve = v; bus1.heater = h; bus1.drum_motor = m;
    bus1.drain_pump = p; bus1.door_lock = l; bus1.inject_imbalance = imb;
    model_step(v, h, m, p, l, imb);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus1.water_valve = 0; bus1.heater = 0; bus1.drum_motor = 0;
    bus1.drain_pump = 0; bus1.door_lock = 0; bus1.inject_imbalance = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus1.water_valve = 1; bus1.heater = 1; bus1.drum_motor = 1;
    bus1.drain_pump = 0; bus1.door_lock = 1; bus1.inject_imbalance = 1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus1.water_level !== 10'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", bus1.water_level); end
    tests_run++;
    if (bus1.temperature_adc !== 10'd100) begin tests_failed++; $display("FAIL reset_temp: got %0d want 100", bus1.temperature_adc); end
    tests_run++;
    if (bus1.motor_speed_sensor !== 10'd0) begin tests_failed++; $display("FAIL reset_speed: got %0d want 0", bus1.motor_speed_sensor); end
    tests_run++;
    if ({bus1.door_locked, bus1.vibration_sensor, bus1.dry_heat_fault} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000", {bus1.door_locked, bus1.vibration_sensor, bus1.dry_heat_fault});
    end
    do_reset();
  endtask

  task automatic test_fill();
    do_reset();
    repeat (64) cyc(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd512) begin tests_failed++; $display("FAIL fill_512: got %0d want 512", bus1.water_level); end
    repeat (63) cyc(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd1016) begin tests_failed++; $display("FAIL fill_1016: got %0d want 1016", bus1.water_level); end
    cyc(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd1023) begin tests_failed++; $display("FAIL fill_sat: got %0d want 1023", bus1.water_level); end
    repeat (5) cyc(1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd1023) begin tests_failed++; $display("FAIL fill_nowrap: got %0d want 1023", bus1.water_level); end
  endtask

  task automatic test_drain();
    do_reset();
    repeat (64) cyc(1, 0, 0, 0, 0, 0);
    repeat (42) cyc(0, 0, 0, 1, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd8) begin tests_failed++; $display("FAIL drain_8: got %0d want 8", bus1.water_level); end
    cyc(0, 0, 0, 1, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd0) begin tests_failed++; $display("FAIL drain_clamp: got %0d want 0", bus1.water_level); end
    repeat (4) cyc(0, 0, 0, 1, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd0) begin tests_failed++; $display("FAIL drain_hold: got %0d want 0", bus1.water_level); end
    cyc(1, 0, 0, 1, 0, 0);
    tests_run++;
    if (bus1.water_level !== 10'd0) begin tests_failed++; $display("FAIL drain_net: got %0d want 0", bus1.water_level); end
  endtask

  task automatic test_heat();
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    tests_run++;
    if (bus1.dry_heat_fault !== 1'b1) begin tests_failed++; $display("FAIL dry_fault: got %b want 1", bus1.dry_heat_fault); end
    tests_run++;
    if (bus1.temperature_adc !== 10'd100) begin tests_failed++; $display("FAIL dry_temp: got %0d want 100", bus1.temperature_adc); end
    repeat (64) cyc(1, 0, 0, 0, 0, 0);
    repeat (100) cyc(0, 1, 0, 0, 0, 0);
    tests_run++;
    if (bus1.temperature_adc !== 10'd300) begin tests_failed++; $display("FAIL heat_300: got %0d want 300", bus1.temperature_adc); end
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus1.temperature_adc !== 10'd295) begin tests_failed++; $display("FAIL cool_295: got %0d want 295", bus1.temperature_adc); end
    tests_run++;
    if (bus1.dry_heat_fault !== 1'b1) begin tests_failed++; $display("FAIL fault_sticky: got %b want 1", bus1.dry_heat_fault); end
  endtask

  task automatic test_motor_vibration();
    do_reset();
    repeat (69) cyc(0, 0, 1, 0, 0, 0);
    tests_run++;
    if (bus1.motor_speed_sensor !== 10'd690) begin tests_failed++; $display("FAIL speed_690: got %0d want 690", bus1.motor_speed_sensor); end
    cyc(0, 0, 1, 0, 0, 1);
    tests_run++;
    if ({bus1.motor_speed_sensor, bus1.vibration_sensor} !== {10'd700, 1'b1}) begin
      tests_failed++; $display("FAIL vib_700: got %0d/%b want 700/1", bus1.motor_speed_sensor, bus1.vibration_sensor);
    end
    cyc(0, 0, 0, 0, 0, 1);
    tests_run++;
    if ({bus1.motor_speed_sensor, bus1.vibration_sensor} !== {10'd680, 1'b0}) begin
      tests_failed++; $display("FAIL vib_680: got %0d/%b want 680/0", bus1.motor_speed_sensor, bus1.vibration_sensor);
    end
    repeat (40) cyc(0, 0, 1, 0, 0, 0);
    tests_run++;
    if (bus1.motor_speed_sensor !== 10'd1000) begin tests_failed++; $display("FAIL speed_max: got %0d want 1000", bus1.motor_speed_sensor); end
  endtask

  task automatic test_door();
    do_reset();
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    tests_run++;
    if (bus1.door_locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early: got %b want 0", bus1.door_locked); end
    cyc(0, 0, 0, 0, 1, 0);
    tests_run++;
    if (bus1.door_locked !== 1'b1) begin tests_failed++; $display("FAIL lock_engage: got %b want 1", bus1.door_locked); end
    repeat (50) cyc(0, 0, 1, 0, 1, 0);
    tests_run++;
    if (bus1.motor_speed_sensor !== 10'd500) begin tests_failed++; $display("FAIL door_speed: got %0d want 500", bus1.motor_speed_sensor); end
    for (int i = 0; i < 28; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (bus1.door_locked !== 1'b1) begin tests_failed++; $display("FAIL interlock_%0d: got %b want 1", i, bus1.door_locked); end
    end
    cyc(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus1.door_locked !== 1'b0) begin tests_failed++; $display("FAIL unlock: got %b want 0", bus1.door_locked); end
  endtask

  task automatic test_random();
    bit v, h, m, p, l, imb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 2) == 0); h = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 1) == 0); p = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 3) != 0); imb = ($urandom_range(0, 1) == 0);
      cyc(v, h, m, p, l, imb);
      tests_run++;
      if (bus1.water_level !== 10'(m_lvl)) begin tests_failed++; $display("FAIL rnd_level_%0d: got %0d want %0d", i, bus1.water_level, m_lvl); end
      tests_run++;
      if (bus1.temperature_adc !== 10'(m_tmp)) begin tests_failed++; $display("FAIL rnd_temp_%0d: got %0d want %0d", i, bus1.temperature_adc, m_tmp); end
      tests_run++;
      if (bus1.motor_speed_sensor !== 10'(m_spd)) begin tests_failed++; $display("FAIL rnd_speed_%0d: got %0d want %0d", i, bus1.motor_speed_sensor, m_spd); end
      tests_run++;
      if ({bus1.door_locked, bus1.vibration_sensor, bus1.dry_heat_fault} !== {m_locked, m_vib, m_fault}) begin
        tests_failed++;
        $display("FAIL rnd_flags_%0d: got %b want %b", i, {bus1.door_locked, bus1.vibration_sensor, bus1.dry_heat_fault}, {m_locked, m_vib, m_fault});
      end
    end
  endtask

  task automatic test_prescaler();
    @(negedge clk);
    rst100 = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    tests_run++;
    if (bus100.water_level !== 10'd0) begin tests_failed++; $display("FAIL div_before: got %0d want 0", bus100.water_level); end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus100.water_level !== 10'd8) begin tests_failed++; $display("FAIL div_first: got %0d want 8", bus100.water_level); end
    repeat (100) @(posedge clk);
    #1;
    tests_run++;
    if ({bus100.water_level, bus100.motor_speed_sensor} !== {10'd16, 10'd20}) begin
      tests_failed++; $display("FAIL div_second: got %0d/%0d want 16/20", bus100.water_level, bus100.motor_speed_sensor);
    end
    repeat (50) @(posedge clk);
    #2;
    rst100 = 1'b1;
    #1;
    tests_run++;
    if ({bus100.water_level, bus100.motor_speed_sensor, bus100.temperature_adc} !== {10'd0, 10'd0, 10'd100}) begin
      tests_failed++;
      $display("FAIL async_reset: got %0d/%0d/%0d want 0/0/100", bus100.water_level, bus100.motor_speed_sensor, bus100.temperature_adc);
    end
    @(negedge clk);
    rst100 = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    tests_run++;
    if (bus100.water_level !== 10'd0) begin tests_failed++; $display("FAIL div_restart: got %0d want 0", bus100.water_level); end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus100.water_level !== 10'd8) begin tests_failed++; $display("FAIL div_restart_tick: got %0d want 8", bus100.water_level); end
  endtask

  initial begin
    rst = 1'b1;
    rst100 = 1'b1;
    bus1.water_valve = 0; bus1.heater = 0; bus1.drum_motor = 0;
    bus1.drain_pump = 0; bus1.door_lock = 0; bus1.inject_imbalance = 0;
    bus100.water_valve = 1; bus100.heater = 0; bus100.drum_motor = 1;
    bus100.drain_pump = 0; bus100.door_lock = 0; bus100.inject_imbalance = 0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_heat();
    test_motor_vibration();
    test_door();
    test_random();
    test_prescaler();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
